// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 4-bit-mode LCD controller: power-up/init sequencer plus byte write port
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_valid/in_ready   byte handshake; in_rs (0=command, 1=char) and in_data latched on transfer
//   reinit              single-cycle request to rerun the init sequence (no power-up wait)
//   init_done           high once init is complete, low during any (re)init
//   en, rs, data        LCD E, RS and D7..D4 (all registered)
module lcd_ctrl #(
  parameter int TICKS_PER_MS = 1,
  parameter int POWERUP_MS   = 40,
  parameter bit TWO_LINE     = 1'b1,
  parameter bit CURSOR_ON    = 1'b0,
  parameter bit BLINK_ON     = 1'b0,
  parameter int LONG_WAIT_MS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  input  logic       reinit,
  output logic       init_done,
  output logic       en,
  output logic       rs,
  output logic [3:0] data
);

  localparam int PW      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int CM0     = (POWERUP_MS > LONG_WAIT_MS) ? POWERUP_MS : LONG_WAIT_MS;
  localparam int CNT_MAX = (CM0 > 5) ? CM0 : 5;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PU_LAST = (POWERUP_MS > 0) ? POWERUP_MS - 1 : 0;
  localparam int LW_LAST = (LONG_WAIT_MS > 0) ? LONG_WAIT_MS - 1 : 0;

  localparam logic [7:0] FUNC_SET  = TWO_LINE ? 8'h28 : 8'h20;
  localparam logic [7:0] DISP_CTRL = {4'h0, 2'b11, CURSOR_ON, BLINK_ON};

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_IDLE, ST_WRITE_HI, ST_WRITE_LO, ST_POSTWAIT
  } state_t;

  // Strobe phases: en-high tick, en-low hold tick, optional post-wait ticks.
  typedef enum logic [1:0] {PH_EN, PH_HOLD, PH_WAIT} phase_t;

  state_t          state, state_n;
  phase_t          phase, phase_n;
  logic [PW-1:0]   presc, presc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      step, step_n;
  logic [7:0]      byte_q, byte_n;
  logic            pend, pend_n;
  logic            en_n, rs_n, in_ready_n, init_done_n;
  logic [3:0]      data_n;
  logic            tick, is_long, start_init, finish;
  int              post;

  // Init steps 0..3 are the bare wake-up nibbles; 4..11 are the four init bytes, high nibble first.
  function automatic logic [3:0] init_nibble(input logic [3:0] s);
    logic [3:0] n;
    case (s)
      4'd0, 4'd1, 4'd2: n = 4'h3;
      4'd3:             n = 4'h2;
      4'd4:             n = FUNC_SET[7:4];
      4'd5:             n = FUNC_SET[3:0];
      4'd6:             n = DISP_CTRL[7:4];
      4'd7:             n = DISP_CTRL[3:0];
      4'd8:             n = 4'h0;
      4'd9:             n = 4'h1;
      4'd10:            n = 4'h0;
      default:          n = 4'h6;
    endcase
    return n;
  endfunction

  function automatic int init_post(input logic [3:0] s);
    int p;
    case (s)
      4'd0, 4'd1: p = 5;
      4'd2:       p = 1;
      4'd9:       p = LONG_WAIT_MS;   // after the clear command
      default:    p = 0;
    endcase
    return p;
  endfunction

  assign tick    = (presc == PW'(TICKS_PER_MS - 1));
  assign is_long = (LONG_WAIT_MS > 0) && !rs &&
                   (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
  assign post    = init_post(step);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_POWERUP;
      phase     <= PH_EN;
      presc     <= '0;
      cnt       <= '0;
      step      <= '0;
      byte_q    <= '0;
      pend      <= 1'b0;
      en        <= 1'b0;
      rs        <= 1'b0;
      data      <= 4'h0;
      in_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      presc     <= presc_n;
      cnt       <= cnt_n;
      step      <= step_n;
      byte_q    <= byte_n;
      pend      <= pend_n;
      en        <= en_n;
      rs        <= rs_n;
      data      <= data_n;
      in_ready  <= in_ready_n;
      init_done <= init_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    presc_n     = tick ? '0 : presc + PW'(1);
    cnt_n       = cnt;
    step_n      = step;
    byte_n      = byte_q;
    pend_n      = pend;
    en_n        = en;
    rs_n        = rs;
    data_n      = data;
    in_ready_n  = in_ready;
    init_done_n = init_done;
    start_init  = 1'b0;
    finish      = 1'b0;

    case (state)
      ST_POWERUP: begin
        if (tick) begin
          if (cnt == CW'(PU_LAST)) start_init = 1'b1;
          else                     cnt_n = cnt + CW'(1);
        end
      end
      ST_INIT: begin
        if (tick) begin
          if (phase == PH_EN) begin
            phase_n = PH_HOLD;
            en_n    = 1'b0;
          end else if ((phase == PH_HOLD && post == 0) ||
                       (phase == PH_WAIT && cnt == CW'(post - 1))) begin
            cnt_n = '0;
            if (step == 4'd11) begin
              state_n     = ST_IDLE;
              in_ready_n  = 1'b1;
              init_done_n = 1'b1;
            end else begin
              step_n  = step + 4'd1;
              phase_n = PH_EN;
              en_n    = 1'b1;
              data_n  = init_nibble(step + 4'd1);
            end
          end else if (phase == PH_HOLD) begin
            phase_n = PH_WAIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ST_IDLE: begin
        // The prescaler restarts here so the first strobe is always a full tick wide.
        if (reinit) begin
          start_init = 1'b1;
          presc_n    = '0;
        end else if (in_valid) begin
          byte_n     = in_data;
          rs_n       = in_rs;
          data_n     = in_data[7:4];
          en_n       = 1'b1;
          in_ready_n = 1'b0;
          phase_n    = PH_EN;
          state_n    = ST_WRITE_HI;
          presc_n    = '0;
        end
      end
      ST_WRITE_HI: begin
        if (tick) begin
          if (phase == PH_EN) begin
            phase_n = PH_HOLD;
            en_n    = 1'b0;
          end else begin
            state_n = ST_WRITE_LO;
            phase_n = PH_EN;
            en_n    = 1'b1;
            data_n  = byte_q[3:0];
          end
        end
      end
      ST_WRITE_LO: begin
        if (tick) begin
          if (phase == PH_EN) begin
            phase_n = PH_HOLD;
            en_n    = 1'b0;
          end else if (is_long) begin
            state_n = ST_POSTWAIT;
            cnt_n   = '0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_POSTWAIT: begin
        if (tick) begin
          if (cnt == CW'(LW_LAST)) finish = 1'b1;
          else                     cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_POWERUP;
    endcase

    // A reinit during a write is remembered and replaces the return to IDLE,
    // so no byte can slip in between.
    if ((state == ST_WRITE_HI || state == ST_WRITE_LO || state == ST_POSTWAIT) && reinit)
      pend_n = 1'b1;

    if (finish) begin
      if (pend_n) begin
        start_init = 1'b1;
      end else begin
        state_n    = ST_IDLE;
        in_ready_n = 1'b1;
      end
    end

    if (start_init) begin
      state_n     = ST_INIT;
      step_n      = 4'd0;
      phase_n     = PH_EN;
      cnt_n       = '0;
      en_n        = 1'b1;
      rs_n        = 1'b0;
      data_n      = init_nibble(4'd0);
      in_ready_n  = 1'b0;
      init_done_n = 1'b0;
      pend_n      = 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - randomized self-checking bench for lcd_ctrl against a nibble-stream model
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       reinit = 1'b0;
  logic       in_ready, init_done, en, rs;
  logic [3:0] data;
  logic       b_in_ready, b_init_done, b_en, b_rs;
  logic [3:0] b_data;

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .reinit(reinit), .init_done(init_done),
    .en(en), .rs(rs), .data(data)
  );

  lcd_ctrl #(.TICKS_PER_MS(4), .TWO_LINE(1'b0), .CURSOR_ON(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(1'b0), .in_ready(b_in_ready),
    .in_rs(1'b0), .in_data(8'h00), .reinit(1'b0), .init_done(b_init_done),
    .en(b_en), .rs(b_rs), .data(b_data)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitors: {rs,data} captured on every en rising edge, and every en pulse width in clk cycles.
  logic [4:0] a_q[$];
  int         a_w[$];
  logic [4:0] b_q[$];
  int         b_w[$];
  logic       a_prev = 1'b0, b_prev = 1'b0;
  int         a_run = 0, b_run = 0;

  always @(negedge clk) begin
    if (en && !a_prev) a_q.push_back({rs, data});
    if (en) a_run++;
    else if (a_prev) begin a_w.push_back(a_run); a_run = 0; end
    a_prev = en;
    if (b_en && !b_prev) b_q.push_back({b_rs, b_data});
    if (b_en) b_run++;
    else if (b_prev) begin b_w.push_back(b_run); b_run = 0; end
    b_prev = b_en;
  end

  // Reference model: expected init nibble stream and init length in ticks.
  logic [4:0] exp_q[$];

  function automatic int expect_init(input bit two_line, input bit cur, input bit blk,
                                     input int powerup, input int long_wait);
    logic [7:0] seq [4];
    exp_q.delete();
    exp_q.push_back(5'h03); exp_q.push_back(5'h03);
    exp_q.push_back(5'h03); exp_q.push_back(5'h02);
    seq[0] = two_line ? 8'h28 : 8'h20;
    seq[1] = 8'h0C | (cur ? 8'h02 : 8'h00) | (blk ? 8'h01 : 8'h00);
    seq[2] = 8'h01;
    seq[3] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, seq[i][7:4]});
      exp_q.push_back({1'b0, seq[i][3:0]});
    end
    // wake-up nibbles: 2 ticks each plus waits 5,5,1,0; bytes: 2 nibbles x 2 ticks plus clear wait
    return powerup + 4 * 2 + 11 + 8 * 2 + long_wait;
  endfunction

  task automatic cmp_q(input string tag, input logic [4:0] got[$]);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(tag, int'(got[i]), int'(exp_q[i]));
  endtask

  // Sends one byte from a negedge; returns the number of cycles in_ready stayed low.
  task automatic do_write(input logic r, input logic [7:0] d, output int low);
    check("idle_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_rs = r; in_data = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_rs = ~r; in_data = ~d;
    low = 0;
    while (!in_ready && low < 50) begin
      low++;
      @(negedge clk);
    end
  endtask

  initial begin
    int a_first, a_done, a_rdy, b_first, b_done, ticks, low, exp_low;
    logic       r;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("rst_en", int'(en), 0);
    check("rst_data", int'(data), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_done", int'(init_done), 0);
    check("rst_b_en", int'(b_en), 0);
    reset = 1'b0;

    a_first = -1; a_done = -1; a_rdy = -1; b_first = -1; b_done = -1;
    for (int n = 1; n <= 400 && b_done < 0; n++) begin
      @(negedge clk);
      if (a_first < 0 && en) a_first = n;
      if (a_done < 0 && init_done) a_done = n;
      if (a_rdy < 0 && in_ready) a_rdy = n;
      if (b_first < 0 && b_en) b_first = n;
      if (b_done < 0 && b_init_done) b_done = n;
    end

    ticks = expect_init(1'b1, 1'b0, 1'b0, 40, 2);
    check("a_first_en", a_first, 40);
    check("a_init_done", a_done, ticks);
    check("a_ready_rise", a_rdy, ticks);
    cmp_q("a_init_nib", a_q);
    for (int i = 0; i < a_w.size(); i++) check("a_width", a_w[i], 1);

    ticks = expect_init(1'b0, 1'b1, 1'b0, 40, 2);
    check("b_first_en", b_first, 40 * 4);
    check("b_init_done", b_done, ticks * 4);
    cmp_q("b_init_nib", b_q);
    check("b_width_cnt", b_w.size(), 12);
    for (int i = 0; i < b_w.size(); i++) check("b_width", b_w[i], 4);

    // Random byte writes; the first three are the fixed "T", clear-command and 0x01-as-char cases.
    for (int i = 0; i < 24; i++) begin
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin r = 1'b0; d = 8'($urandom_range(1, 3)); end
      if (i == 0) begin r = 1'b1; d = 8'h54; end
      if (i == 1) begin r = 1'b0; d = 8'h01; end
      if (i == 2) begin r = 1'b1; d = 8'h01; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a_q.delete(); a_w.delete();
      do_write(r, d, low);
      exp_low = (!r && d >= 8'h01 && d <= 8'h03) ? 4 + 2 : 4;
      check("wr_ready_low", low, exp_low);
      exp_q.delete();
      exp_q.push_back({r, d[7:4]});
      exp_q.push_back({r, d[3:0]});
      cmp_q("wr_nib", a_q);
    end

    // reinit together with in_valid in IDLE: reinit wins, byte dropped, no power-up wait.
    @(negedge clk);
    a_q.delete(); a_w.delete();
    reinit = 1'b1; in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    reinit = 1'b0; in_valid = 1'b0;
    check("ri_done_low", int'(init_done), 0);
    check("ri_ready_low", int'(in_ready), 0);
    low = 0;
    while (!init_done && low < 200) begin
      low++;
      @(negedge clk);
    end
    ticks = expect_init(1'b1, 1'b0, 1'b0, 0, 2);
    check("ri_len", low, ticks);
    cmp_q("ri_nib", a_q);

    // reinit during a write: write completes, init reruns, held in_valid never accepted.
    @(negedge clk);
    a_q.delete(); a_w.delete();
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h54;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'hAA;
    low = 0;
    while (!in_ready && low < 200) begin
      low++;
      reinit = (low == 2);
      if (low == 5) check("pend_done_low", int'(init_done), 0);
      @(negedge clk);
    end
    in_valid = 1'b0; reinit = 1'b0;
    check("pend_len", low, 4 + ticks);
    check("pend_done", int'(init_done), 1);
    void'(expect_init(1'b1, 1'b0, 1'b0, 0, 2));
    exp_q.push_front(5'h14);
    exp_q.push_front(5'h15);
    cmp_q("pend_nib", a_q);

    // Reset while en is high mid-write aborts and reruns the full power-up.
    @(negedge clk);
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h54;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mw_en", int'(en), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mw_rst_en", int'(en), 0);
    check("mw_rst_data", int'(data), 0);
    check("mw_rst_done", int'(init_done), 0);
    check("mw_rst_ready", int'(in_ready), 0);
    reset = 1'b0;
    low = 0;
    while (!en && low < 200) begin
      low++;
      @(negedge clk);
    end
    check("mw_powerup", low, 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Parametrised HD44780 4-bit-mode LCD controller. Next generation of the fixed-sequence LCD init driver.
- Runs the power-up and init sequence from a configurable tick base, then accepts arbitrary command/character bytes over a valid/ready handshake.
- Splits each byte into two enable-strobed nibbles and inserts the long execution delay after clear/home commands.
- Sits between the design's text/command source and the LCD pins.

Parameters:
- TICKS_PER_MS, 1, clk cycles per 1 ms timing tick (1 = 1 kHz clock, every cycle is a tick).
- POWERUP_MS, 40, ticks waited after reset before the first init nibble.
- TWO_LINE, 1, function set byte is 0x28 when 1, 0x20 when 0.
- CURSOR_ON, 0, display-control bit 1.
- BLINK_ON, 0, display-control bit 0.
- LONG_WAIT_MS, 2, extra ticks after clear (0x01) or home (0x02/0x03) commands.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte offered.
- in_ready  out  1  controller can accept a byte this cycle.
- in_rs  in  1  0 = command, 1 = character data.
- in_data  in  8  byte to write.
- reinit  in  1  single-cycle request to rerun the init sequence (powerup wait skipped).
- init_done  out  1  high once init completes; low during any (re)init.
- en  out  1  LCD E.
- rs  out  1  LCD RS.
- data  out  4  LCD D7..D4.

Behaviour:
- Reset (synchronous, wins over everything): en=0, rs=0, data=0, in_ready=0, init_done=0, prescaler=0, any pending reinit cleared, state=POWERUP. Reset mid-write or mid-init aborts immediately; no partial strobe completes.
- Tick: prescaler counts 0..TICKS_PER_MS-1. A tick is the cycle it wraps. The FSM advances only on ticks, except in IDLE. The prescaler is zeroed on every accept, so write timing is deterministic from the handshake.
- Nibble strobe: 1 tick with en=1 and data/rs driven together, then 1 tick with en=0 (data/rs held), then any post-wait ticks with en=0.
- Outputs are registered.
- States:
  - POWERUP: POWERUP_MS ticks, en=0.
  - INIT: rs=0 nibbles 3,3,3,2, with post-waits of 5, 5, 1 and 0 ticks. Then bytes function set (per TWO_LINE), 0x08|0x04|CURSOR_ON<<1|BLINK_ON, 0x01 (post-wait LONG_WAIT_MS), 0x06. Each byte is sent high nibble then low nibble with no post-wait unless stated.
  - IDLE: in_ready=1, init_done=1.
  - WRITE_HI, WRITE_LO: strobe the high then the low nibble with rs=in_rs latched.
  - POSTWAIT: LONG_WAIT_MS ticks when the latched in_rs=0 and the latched byte is 0x01, 0x02 or 0x03; otherwise skipped. Return to IDLE.
- Handshake: transfer when in_valid && in_ready on a clk edge. in_rs/in_data are latched then and in_ready drops the next cycle. in_ready stays 0 in every non-IDLE state and reasserts on the first cycle back in IDLE. in_valid outside IDLE is ignored; the source holds it. Only one byte is in flight; there is no buffering.
- Write latency (TICKS_PER_MS=1): en=1 the cycle after accept. Ordinary byte: in_ready back 4 cycles after accept. Clear/home: 4+LONG_WAIT_MS cycles.
- reinit:
  - Pulse in IDLE: init_done=0, in_ready=0, restart at the first INIT nibble. If in_valid is also high that cycle, reinit wins and the byte is not accepted.
  - Pulse during a write: latched, taken on return to IDLE (no accept in between).
  - Pulse during POWERUP/INIT: ignored.
- Init length: 40+24+13 = 77 ticks. init_done and in_ready rise on the first cycle after the 77th tick.
- Widths: the powerup counter is wide enough for POWERUP_MS; the prescaler for TICKS_PER_MS-1. A TICKS_PER_MS of 1 must not produce a zero-width counter.

Test Plan:
- Default params, reset 3 cycles then release -> en=0 for 40 cycles. Nibble stream on en rising edges is 3,3,3,2,2,8,0,C,0,1,0,6, all rs=0. init_done=1 and in_ready=1 77 cycles after release.
- After init, send in_rs=1, in_data=0x54 ("T") -> en pulses with data 5 then 4, rs=1. in_ready low 4 cycles then high.
- Send in_rs=0, 0x01 -> nibbles 0,1, then in_ready stays low 2 more cycles (6 total). Send in_rs=1, 0x01 -> 4 cycles only.
- TICKS_PER_MS=4, TWO_LINE=0, CURSOR_ON=1 -> each en pulse is 4 clk wide, init bytes include 0x20 and 0x0E, init_done after 308 cycles.
- reinit and in_valid together in IDLE -> byte not accepted, init_done drops. The nibble sequence restarts at 3 without the 40-tick wait, and init_done returns 37 ticks later.
- Reset asserted while en=1 mid-write -> next cycle en=0, data=0, init_done=0. The full 40-tick powerup is re-run.
